// File: rtl/axi_m_port_if.sv
// Bundle of the AXI4 master-side channels and the packed crossbar arbiter handshakes.
// The slave modport is the port adapter; the master modport is its environment.
interface axi_m_port_if;
    logic [3:0]  ARID_i;
    logic [31:0] ARADDR_i;
    logic [3:0]  ARLEN_i;
    logic [2:0]  ARSIZE_i;
    logic [1:0]  ARBURST_i;
    logic        ARVALID_i;
    logic        ARREADY_o;

    logic [3:0]  AWID_i;
    logic [31:0] AWADDR_i;
    logic [3:0]  AWLEN_i;
    logic [2:0]  AWSIZE_i;
    logic [1:0]  AWBURST_i;
    logic        AWVALID_i;
    logic        AWREADY_o;

    logic [31:0] WDATA_i;
    logic [3:0]  WSTRB_i;
    logic        WLAST_i;
    logic        WVALID_i;
    logic        WREADY_o;

    logic [3:0]  RID_o;
    logic [31:0] RDATA_o;
    logic [1:0]  RRESP_o;
    logic        RLAST_o;
    logic        RVALID_o;
    logic        RREADY_i;

    logic [3:0]  BID_o;
    logic [1:0]  BRESP_o;
    logic        BVALID_o;
    logic        BREADY_i;

    logic        AR_VALID_o;
    logic [48:0] AR_DATA_o;
    logic        AR_GRANT_i;
    logic        AW_VALID_o;
    logic [48:0] AW_DATA_o;
    logic        AW_GRANT_i;
    logic        W_VALID_o;
    logic [36:0] W_DATA_o;
    logic        W_GRANT_i;
    logic        R_VALID_i;
    logic [42:0] R_DATA_i;
    logic        R_POP_o;
    logic        B_VALID_i;
    logic [9:0]  B_DATA_i;
    logic        B_POP_o;
    logic        WLAST_ERR_o;

    modport slave (
        input  ARID_i, ARADDR_i, ARLEN_i, ARSIZE_i, ARBURST_i, ARVALID_i,
        output ARREADY_o,
        input  AWID_i, AWADDR_i, AWLEN_i, AWSIZE_i, AWBURST_i, AWVALID_i,
        output AWREADY_o,
        input  WDATA_i, WSTRB_i, WLAST_i, WVALID_i,
        output WREADY_o,
        output RID_o, RDATA_o, RRESP_o, RLAST_o, RVALID_o,
        input  RREADY_i,
        output BID_o, BRESP_o, BVALID_o,
        input  BREADY_i,
        output AR_VALID_o, AR_DATA_o,
        input  AR_GRANT_i,
        output AW_VALID_o, AW_DATA_o,
        input  AW_GRANT_i,
        output W_VALID_o, W_DATA_o,
        input  W_GRANT_i,
        input  R_VALID_i, R_DATA_i,
        output R_POP_o,
        input  B_VALID_i, B_DATA_i,
        output B_POP_o,
        output WLAST_ERR_o
    );

    modport master (
        output ARID_i, ARADDR_i, ARLEN_i, ARSIZE_i, ARBURST_i, ARVALID_i,
        input  ARREADY_o,
        output AWID_i, AWADDR_i, AWLEN_i, AWSIZE_i, AWBURST_i, AWVALID_i,
        input  AWREADY_o,
        output WDATA_i, WSTRB_i, WLAST_i, WVALID_i,
        input  WREADY_o,
        input  RID_o, RDATA_o, RRESP_o, RLAST_o, RVALID_o,
        output RREADY_i,
        input  BID_o, BRESP_o, BVALID_o,
        output BREADY_i,
        input  AR_VALID_o, AR_DATA_o,
        output AR_GRANT_i,
        input  AW_VALID_o, AW_DATA_o,
        output AW_GRANT_i,
        input  W_VALID_o, W_DATA_o,
        output W_GRANT_i,
        output R_VALID_i, R_DATA_i,
        input  R_POP_o,
        output B_VALID_i, B_DATA_i,
        input  B_POP_o,
        input  WLAST_ERR_o
    );
endinterface

// File: rtl/axi_m_port.sv
// Master-side crossbar port: packs AR/AW/W into arbiter request words, returns R/B, limits
// outstanding transactions. Define AXI_M_PORT_LAST_CHK_EN to flag WLAST/AWLEN disagreement.
module axi_m_port #(
    parameter logic [3:0]  MASTER_ID       = 4'd0,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input logic         AXI_CLK_i,
    input logic         AXI_RST_i,
    axi_m_port_if.slave bus
);
    localparam logic [3:0] MaxOut = 4'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {WIdle, WData} w_state_e;

    w_state_e    w_state_q;
    logic        ar_full_q, aw_full_q, w_full_q;
    logic [48:0] ar_data_q, aw_data_q;
    logic [36:0] w_data_q;
    logic [3:0]  rd_cnt_q, wr_cnt_q, len_q, beat_cnt_q;

    logic ar_accept, ar_grant, aw_accept, aw_grant, w_accept, w_grant;
    logic beat_last, rd_done, wr_done;

    // Saturating at both ends; simultaneous inc and dec cancel.
    function automatic logic [3:0] cnt_next(logic [3:0] cnt, logic inc, logic dec);
        if (inc && !dec && cnt < MaxOut) return cnt + 4'd1;
        if (dec && !inc && cnt != 4'd0) return cnt - 4'd1;
        return cnt;
    endfunction

    assign bus.ARREADY_o = ~ar_full_q & (rd_cnt_q < MaxOut);
    assign bus.AWREADY_o = (w_state_q == WIdle) & ~aw_full_q & (wr_cnt_q < MaxOut);
    assign bus.WREADY_o  = (w_state_q == WData) & ~w_full_q;

    assign ar_accept = bus.ARVALID_i & bus.ARREADY_o;
    assign aw_accept = bus.AWVALID_i & bus.AWREADY_o;
    assign w_accept  = bus.WVALID_i & bus.WREADY_o;
    assign ar_grant  = ar_full_q & bus.AR_GRANT_i;
    assign aw_grant  = aw_full_q & bus.AW_GRANT_i;
    assign w_grant   = w_full_q & bus.W_GRANT_i;
    assign beat_last = (beat_cnt_q == len_q);

    assign bus.AR_VALID_o = ar_full_q;
    assign bus.AR_DATA_o  = ar_data_q;
    assign bus.AW_VALID_o = aw_full_q;
    assign bus.AW_DATA_o  = aw_data_q;
    assign bus.W_VALID_o  = w_full_q;
    assign bus.W_DATA_o   = w_data_q;

    assign bus.RVALID_o = bus.R_VALID_i;
    assign bus.RID_o    = bus.R_DATA_i[38:35];
    assign bus.RDATA_o  = bus.R_DATA_i[34:3];
    assign bus.RRESP_o  = bus.R_DATA_i[2:1];
    assign bus.RLAST_o  = bus.R_DATA_i[0];
    assign bus.R_POP_o  = bus.R_VALID_i & bus.RREADY_i;
    assign rd_done      = bus.R_POP_o & bus.R_DATA_i[0];

    assign bus.BVALID_o = bus.B_VALID_i;
    assign bus.BID_o    = bus.B_DATA_i[5:2];
    assign bus.BRESP_o  = bus.B_DATA_i[1:0];
    assign bus.B_POP_o  = bus.B_VALID_i & bus.BREADY_i;
    assign wr_done      = bus.B_POP_o;

    // Master-ID half of the returned tags is implied by the routing, not needed here.
    logic unused_bits;
    assign unused_bits = ^{bus.R_DATA_i[42:39], bus.B_DATA_i[9:6], bus.WLAST_i};

    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            ar_full_q <= 1'b0;
            ar_data_q <= '0;
            rd_cnt_q  <= '0;
        end else begin
            if (ar_accept) begin
                ar_full_q <= 1'b1;
                ar_data_q <= {MASTER_ID, bus.ARID_i, bus.ARADDR_i, bus.ARLEN_i,
                              bus.ARSIZE_i, bus.ARBURST_i};
            end else if (ar_grant) begin
                ar_full_q <= 1'b0;
            end
            rd_cnt_q <= cnt_next(rd_cnt_q, ar_grant, rd_done);
        end
    end

`ifdef AXI_M_PORT_LAST_CHK_EN
    logic wlast_err_q;
    assign bus.WLAST_ERR_o = wlast_err_q;
`else
    assign bus.WLAST_ERR_o = 1'b0;
`endif

    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            w_state_q  <= WIdle;
            aw_full_q  <= 1'b0;
            aw_data_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            wr_cnt_q   <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
`ifdef AXI_M_PORT_LAST_CHK_EN
            wlast_err_q <= 1'b0;
`endif
        end else begin
            if (aw_accept) begin
                aw_full_q <= 1'b1;
                aw_data_q <= {MASTER_ID, bus.AWID_i, bus.AWADDR_i, bus.AWLEN_i,
                              bus.AWSIZE_i, bus.AWBURST_i};
            end else if (aw_grant) begin
                aw_full_q <= 1'b0;
            end
            // Forwarded LAST comes from the beat count, never from WLAST_i.
            if (w_accept) begin
                w_full_q <= 1'b1;
                w_data_q <= {bus.WDATA_i, bus.WSTRB_i, beat_last};
            end else if (w_grant) begin
                w_full_q <= 1'b0;
            end
            wr_cnt_q <= cnt_next(wr_cnt_q, aw_grant, wr_done);
            unique case (w_state_q)
                WIdle: begin
                    if (aw_accept) begin
                        len_q      <= bus.AWLEN_i;
                        beat_cnt_q <= '0;
                        w_state_q  <= WData;
                    end
                end
                WData: begin
                    if (w_accept) begin
                        beat_cnt_q <= beat_cnt_q + 4'd1;
                        if (beat_last) w_state_q <= WIdle;
                    end
                end
            endcase
`ifdef AXI_M_PORT_LAST_CHK_EN
            if (w_accept && (bus.WLAST_i != beat_last)) wlast_err_q <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_axi_m_port.sv
// Bench for axi_m_port: directed corner sequences, a response-path vector table and a
// randomized run checked against a queue-based transaction model.
module tb_axi_m_port;
    localparam logic [3:0] MId = 4'd2;
    localparam int MaxOut = 2;
`ifdef AXI_M_PORT_LAST_CHK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;

    axi_m_port_if bus ();

    axi_m_port #(.MASTER_ID(MId), .MAX_OUTSTANDING(MaxOut)) dut (
        .AXI_CLK_i(clk),
        .AXI_RST_i(rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [48:0] pack_a(logic [3:0] id, logic [31:0] addr, logic [3:0] len,
                                           logic [2:0] size, logic [1:0] burst);
        return {MId, id, addr, len, size, burst};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ARID_i = '0; bus.ARADDR_i = '0; bus.ARLEN_i = '0; bus.ARSIZE_i = '0;
        bus.ARBURST_i = '0; bus.ARVALID_i = 1'b0;
        bus.AWID_i = '0; bus.AWADDR_i = '0; bus.AWLEN_i = '0; bus.AWSIZE_i = '0;
        bus.AWBURST_i = '0; bus.AWVALID_i = 1'b0;
        bus.WDATA_i = '0; bus.WSTRB_i = '0; bus.WLAST_i = 1'b0; bus.WVALID_i = 1'b0;
        bus.RREADY_i = 1'b0; bus.BREADY_i = 1'b0;
        bus.AR_GRANT_i = 1'b0; bus.AW_GRANT_i = 1'b0; bus.W_GRANT_i = 1'b0;
        bus.R_VALID_i = 1'b0; bus.R_DATA_i = '0; bus.B_VALID_i = 1'b0; bus.B_DATA_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic aw_req(input logic [3:0] len);
        bus.AWVALID_i = 1'b1; bus.AWID_i = 4'h3; bus.AWADDR_i = 32'h2000_0000;
        bus.AWLEN_i = len; bus.AWSIZE_i = 3'd2; bus.AWBURST_i = 2'd1;
        cyc();
        bus.AWVALID_i = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic wlast);
        bus.WVALID_i = 1'b1; bus.WDATA_i = data; bus.WSTRB_i = 4'hF; bus.WLAST_i = wlast;
        cyc();
        bus.WVALID_i = 1'b0;
    endtask

    typedef struct {
        logic r_valid; logic [7:0] r_id; logic r_last; logic rready;
        logic b_valid; logic [7:0] b_id; logic bready;
        logic e_rvalid; logic [3:0] e_rid; logic e_rpop;
        logic e_bvalid; logic [3:0] e_bid; logic e_bpop;
    } vec_t;
    vec_t vecs[5];

    // Behavioural model state for the randomized run.
    logic [48:0] m_ar[$];
    logic [48:0] m_aw[$];
    logic [36:0] m_w[$];
    int m_rd, m_wr, m_len, m_beat;
    bit m_burst, m_err;

    initial begin
        clear_inputs();
        #3;
        check("rst_ar_valid", bus.AR_VALID_o, 0);
        check("rst_aw_valid", bus.AW_VALID_o, 0);
        check("rst_w_valid", bus.W_VALID_o, 0);
        check("rst_ready", {bus.ARREADY_o, bus.AWREADY_o, bus.WREADY_o}, 3'b110);
        check("rst_wlast_err", bus.WLAST_ERR_o, 0);
        cyc();
        rst_n = 1'b1;

        // Single read
        bus.ARVALID_i = 1'b1; bus.ARID_i = 4'h5; bus.ARADDR_i = 32'h1000_0040;
        bus.ARLEN_i = 4'd3; bus.ARSIZE_i = 3'd2; bus.ARBURST_i = 2'd1;
        #1;
        check("rd_ready_idle", bus.ARREADY_o, 1);
        check("rd_valid_pre", bus.AR_VALID_o, 0);
        cyc();
        bus.ARVALID_i = 1'b0;
        #1;
        check("rd_valid_post", bus.AR_VALID_o, 1);
        check("rd_data", bus.AR_DATA_o, {8'h25, 32'h1000_0040, 4'd3, 3'd2, 2'd1});
        check("rd_ready_full", bus.ARREADY_o, 0);
        cyc();
        check("rd_hold", {bus.AR_VALID_o, bus.AR_DATA_o}, {1'b1, pack_a(5, 32'h1000_0040, 3, 2, 1)});
        bus.AR_GRANT_i = 1'b1;
        cyc();
        bus.AR_GRANT_i = 1'b0;
        #1;
        check("rd_granted", {bus.AR_VALID_o, bus.ARREADY_o}, 2'b01);

        // Outstanding limit (one read already in flight)
        bus.ARVALID_i = 1'b1; bus.ARID_i = 4'h6;
        cyc();
        bus.ARVALID_i = 1'b0; bus.AR_GRANT_i = 1'b1;
        cyc();
        bus.AR_GRANT_i = 1'b0;
        #1;
        check("lim_ready_low", bus.ARREADY_o, 0);
        bus.ARVALID_i = 1'b1; bus.ARID_i = 4'h7;
        cyc();
        check("lim_no_accept", bus.AR_VALID_o, 0);
        bus.R_VALID_i = 1'b1; bus.RREADY_i = 1'b1; bus.R_DATA_i = {8'h25, 32'h0, 2'b00, 1'b0};
        cyc();
        check("lim_nonlast_pop", bus.ARREADY_o, 0);
        bus.R_DATA_i = {8'h25, 32'h0, 2'b00, 1'b1};
        #1;
        check("lim_r_pop", bus.R_POP_o, 1);
        cyc();
        bus.R_VALID_i = 1'b0; bus.RREADY_i = 1'b0;
        #1;
        check("lim_ready_back", bus.ARREADY_o, 1);
        cyc();
        bus.ARVALID_i = 1'b0;
        #1;
        check("lim_third", {bus.AR_VALID_o, bus.AR_DATA_o}, {1'b1, pack_a(7, 32'h1000_0040, 3, 2, 1)});
        do_reset();

        // Write burst, AWLEN=2
        bus.AWVALID_i = 1'b1; bus.AWID_i = 4'h3; bus.AWADDR_i = 32'h2000_0000;
        bus.AWLEN_i = 4'd2; bus.AWSIZE_i = 3'd2; bus.AWBURST_i = 2'd1;
        bus.WVALID_i = 1'b1; bus.WDATA_i = 32'h55;
        #1;
        check("wr_pre_ready", {bus.AWREADY_o, bus.WREADY_o}, 2'b10);
        cyc();
        bus.AWVALID_i = 1'b0; bus.WVALID_i = 1'b0;
        #1;
        check("wr_aw_word", {bus.AW_VALID_o, bus.AW_DATA_o}, {1'b1, pack_a(3, 32'h2000_0000, 2, 2, 1)});
        check("wr_no_early_w", bus.W_VALID_o, 0);
        check("wr_ready_data", {bus.AWREADY_o, bus.WREADY_o}, 2'b01);
        for (int b = 0; b < 3; b++) begin
            w_beat(32'hA000_0000 + 32'(b), b == 2);
            #1;
            check("wr_beat", {bus.W_VALID_o, bus.W_DATA_o, bus.WREADY_o},
                  {1'b1, 32'hA000_0000 + 32'(b), 4'hF, b == 2, 1'b0});
            bus.W_GRANT_i = 1'b1;
            cyc();
            bus.W_GRANT_i = 1'b0;
            #1;
            check("wr_after_grant", {bus.W_VALID_o, bus.WREADY_o}, {1'b0, b < 2});
        end
        check("wr_aw_pending", bus.AWREADY_o, 0);
        bus.AW_GRANT_i = 1'b1;
        cyc();
        bus.AW_GRANT_i = 1'b0;
        #1;
        check("wr_aw_granted", {bus.AW_VALID_o, bus.AWREADY_o}, 2'b01);
        do_reset();

        // WLAST mismatch, AWLEN=1 with WLAST on both beats
        aw_req(4'd1);
        w_beat(32'h1, 1'b1);
        #1;
        check("mm_last0", bus.W_DATA_o[0], 0);
        check("mm_err", bus.WLAST_ERR_o, ChkEn);
        bus.W_GRANT_i = 1'b1;
        cyc();
        bus.W_GRANT_i = 1'b0;
        w_beat(32'h2, 1'b1);
        #1;
        check("mm_last1", {bus.W_DATA_o[0], bus.WLAST_ERR_o}, {1'b1, ChkEn});
        do_reset();
        #1;
        check("mm_err_cleared", bus.WLAST_ERR_o, 0);

        // Response-path vectors
        vecs[0] = '{1, 8'h27, 1, 0, 0, 8'h00, 0, 1, 4'h7, 0, 0, 4'h0, 0};
        vecs[1] = '{1, 8'h27, 1, 1, 0, 8'h00, 0, 1, 4'h7, 1, 0, 4'h0, 0};
        vecs[2] = '{0, 8'h2A, 0, 1, 1, 8'h2C, 0, 0, 4'hA, 0, 1, 4'hC, 0};
        vecs[3] = '{1, 8'h23, 0, 1, 1, 8'h29, 1, 1, 4'h3, 1, 1, 4'h9, 1};
        vecs[4] = '{0, 8'h20, 0, 0, 0, 8'h2F, 1, 0, 4'h0, 0, 0, 4'hF, 0};
        for (int i = 0; i < 5; i++) begin
            bus.R_VALID_i = vecs[i].r_valid; bus.RREADY_i = vecs[i].rready;
            bus.R_DATA_i = {vecs[i].r_id, 32'hDEAD_BEEF, 2'b10, vecs[i].r_last};
            bus.B_VALID_i = vecs[i].b_valid; bus.BREADY_i = vecs[i].bready;
            bus.B_DATA_i = {vecs[i].b_id, 2'b01};
            #1;
            check("vec_r", {bus.RVALID_o, bus.RID_o, bus.RDATA_o, bus.RRESP_o, bus.RLAST_o, bus.R_POP_o},
                  {vecs[i].e_rvalid, vecs[i].e_rid, 32'hDEAD_BEEF, 2'b10, vecs[i].r_last,
                   vecs[i].e_rpop});
            check("vec_b", {bus.BVALID_o, bus.BID_o, bus.BRESP_o, bus.B_POP_o},
                  {vecs[i].e_bvalid, vecs[i].e_bid, 2'b01, vecs[i].e_bpop});
            cyc();
        end
        clear_inputs();
        #1;
        check("pop_at_zero", {bus.ARREADY_o, bus.AWREADY_o}, 2'b11);

        // B pop and AW grant in the same cycle
        aw_req(4'd0);
        w_beat(32'h10, 1'b1);
        bus.W_GRANT_i = 1'b1; bus.AW_GRANT_i = 1'b1;
        cyc();
        bus.W_GRANT_i = 1'b0; bus.AW_GRANT_i = 1'b0;
        aw_req(4'd0);
        w_beat(32'h11, 1'b1);
        bus.W_GRANT_i = 1'b1; bus.AW_GRANT_i = 1'b1; bus.B_VALID_i = 1'b1; bus.BREADY_i = 1'b1;
        cyc();
        clear_inputs();
        #1;
        check("inc_dec_same", bus.AWREADY_o, 1);
        aw_req(4'd0);
        w_beat(32'h12, 1'b1);
        bus.W_GRANT_i = 1'b1; bus.AW_GRANT_i = 1'b1;
        cyc();
        clear_inputs();
        #1;
        check("wr_limit", bus.AWREADY_o, 0);
        do_reset();

        // Reset mid-burst
        bus.ARVALID_i = 1'b1;
        aw_req(4'd3);
        bus.ARVALID_i = 1'b0;
        w_beat(32'h77, 1'b0);
        #1;
        check("mid_pre", {bus.AR_VALID_o, bus.AW_VALID_o, bus.W_VALID_o}, 3'b111);
        rst_n = 1'b0;
        #1;
        check("mid_valids", {bus.AR_VALID_o, bus.AW_VALID_o, bus.W_VALID_o}, 3'b000);
        check("mid_ready", {bus.ARREADY_o, bus.AWREADY_o, bus.WREADY_o}, 3'b110);
        cyc();
        rst_n = 1'b1;
        #1;
        check("mid_idle", {bus.AWREADY_o, bus.WREADY_o}, 2'b10);

        // Randomized run against the transaction model
        do_reset();
        m_rd = 0; m_wr = 0; m_len = 0; m_beat = 0; m_burst = 0; m_err = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] r_id, b_id;
            logic [31:0] r_data;
            logic [1:0] r_resp, b_resp;
            logic r_last, e_arr, e_awr, e_wr;
            logic ar_acc, ar_gnt, aw_acc, aw_gnt, w_acc, w_gnt, r_pop, b_pop, w_last;

            bus.ARVALID_i = ($urandom_range(0, 1) == 1);
            bus.ARID_i = 4'($urandom); bus.ARADDR_i = $urandom; bus.ARLEN_i = 4'($urandom);
            bus.ARSIZE_i = 3'($urandom); bus.ARBURST_i = 2'($urandom);
            bus.AWVALID_i = ($urandom_range(0, 4) < 2);
            bus.AWID_i = 4'($urandom); bus.AWADDR_i = $urandom; bus.AWLEN_i = 4'($urandom_range(0, 3));
            bus.AWSIZE_i = 3'($urandom); bus.AWBURST_i = 2'($urandom);
            bus.WVALID_i = ($urandom_range(0, 4) < 3);
            bus.WDATA_i = $urandom; bus.WSTRB_i = 4'($urandom); bus.WLAST_i = 1'($urandom);
            bus.AR_GRANT_i = 1'($urandom); bus.AW_GRANT_i = 1'($urandom); bus.W_GRANT_i = 1'($urandom);
            r_id = 8'($urandom); r_data = $urandom; r_resp = 2'($urandom); r_last = 1'($urandom);
            bus.R_VALID_i = ($urandom_range(0, 9) < 3); bus.RREADY_i = ($urandom_range(0, 9) < 7);
            bus.R_DATA_i = {r_id, r_data, r_resp, r_last};
            b_id = 8'($urandom); b_resp = 2'($urandom);
            bus.B_VALID_i = ($urandom_range(0, 9) < 3); bus.BREADY_i = ($urandom_range(0, 9) < 7);
            bus.B_DATA_i = {b_id, b_resp};
            #1;

            e_arr = (m_ar.size() == 0) && (m_rd < MaxOut);
            e_awr = !m_burst && (m_aw.size() == 0) && (m_wr < MaxOut);
            e_wr = m_burst && (m_w.size() == 0);
            check("rnd_ready", {bus.ARREADY_o, bus.AWREADY_o, bus.WREADY_o}, {e_arr, e_awr, e_wr});
            check("rnd_valids", {bus.AR_VALID_o, bus.AW_VALID_o, bus.W_VALID_o},
                  {m_ar.size() != 0, m_aw.size() != 0, m_w.size() != 0});
            if (m_ar.size() != 0) check("rnd_ar_data", bus.AR_DATA_o, m_ar[0]);
            if (m_aw.size() != 0) check("rnd_aw_data", bus.AW_DATA_o, m_aw[0]);
            if (m_w.size() != 0) check("rnd_w_data", bus.W_DATA_o, m_w[0]);
            r_pop = bus.R_VALID_i && bus.RREADY_i;
            b_pop = bus.B_VALID_i && bus.BREADY_i;
            check("rnd_r", {bus.RVALID_o, bus.RID_o, bus.RDATA_o, bus.RRESP_o, bus.RLAST_o, bus.R_POP_o},
                  {bus.R_VALID_i, r_id[3:0], r_data, r_resp, r_last, r_pop});
            check("rnd_b", {bus.BVALID_o, bus.BID_o, bus.BRESP_o, bus.B_POP_o},
                  {bus.B_VALID_i, b_id[3:0], b_resp, b_pop});
            check("rnd_err", bus.WLAST_ERR_o, m_err);

            ar_acc = bus.ARVALID_i && e_arr;
            ar_gnt = (m_ar.size() != 0) && bus.AR_GRANT_i;
            aw_acc = bus.AWVALID_i && e_awr;
            aw_gnt = (m_aw.size() != 0) && bus.AW_GRANT_i;
            w_acc = bus.WVALID_i && e_wr;
            w_gnt = (m_w.size() != 0) && bus.W_GRANT_i;
            cyc();

            if (ar_gnt) void'(m_ar.pop_front());
            if (ar_acc) m_ar.push_back(pack_a(bus.ARID_i, bus.ARADDR_i, bus.ARLEN_i,
                                              bus.ARSIZE_i, bus.ARBURST_i));
            if (ar_gnt && !(r_pop && r_last)) m_rd = (m_rd < MaxOut) ? m_rd + 1 : m_rd;
            if (!ar_gnt && r_pop && r_last) m_rd = (m_rd > 0) ? m_rd - 1 : 0;
            if (aw_gnt) void'(m_aw.pop_front());
            if (aw_acc) begin
                m_aw.push_back(pack_a(bus.AWID_i, bus.AWADDR_i, bus.AWLEN_i,
                                      bus.AWSIZE_i, bus.AWBURST_i));
                m_burst = 1; m_len = int'(bus.AWLEN_i); m_beat = 0;
            end
            if (aw_gnt && !b_pop) m_wr = (m_wr < MaxOut) ? m_wr + 1 : m_wr;
            if (!aw_gnt && b_pop) m_wr = (m_wr > 0) ? m_wr - 1 : 0;
            if (w_gnt) void'(m_w.pop_front());
            if (w_acc) begin
                w_last = (m_beat == m_len);
                m_w.push_back({bus.WDATA_i, bus.WSTRB_i, w_last});
                if (ChkEn && (bus.WLAST_i != w_last)) m_err = 1;
                m_beat++;
                if (w_last) m_burst = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_m_port.md
# axi_m_port

Master-side port adapter of the crossbar. Converts one AXI4 master's native AR/AW/W channels into the packed request words and valid/grant handshakes consumed by the crossbar's per-channel priority arbiters, and returns packed R/B words to the master. Handles ID tagging and outstanding-transaction limits, and sequences write data behind its address. One instance per master, upstream of the slave-side interface arbiters and clock-crossing FIFOs.

## Interface
- MASTER_ID, default 0: 4-bit tag placed in ID[7:4] of every request.
- MAX_OUTSTANDING, default 4, range 1..15: maximum in-flight reads, and separately in-flight writes.
- AXI_CLK_i in 1: clock. One clock domain.
- AXI_RST_i in 1: reset, asynchronous, active-low.
- ARID_i/AWID_i in 4; ARADDR_i/AWADDR_i in 32; ARLEN_i/AWLEN_i in 4; ARSIZE_i/AWSIZE_i in 3; ARBURST_i/AWBURST_i in 2; ARVALID_i/AWVALID_i in 1: master address channels.
- ARREADY_o/AWREADY_o out 1: address accept.
- WDATA_i in 32; WSTRB_i in 4; WLAST_i in 1; WVALID_i in 1; WREADY_o out 1: master write data.
- RID_o out 4; RDATA_o out 32; RRESP_o out 2; RLAST_o out 1; RVALID_o out 1; RREADY_i in 1: master read data.
- BID_o out 4; BRESP_o out 2; BVALID_o out 1; BREADY_i in 1: master write response.
- AR_VALID_o out 1; AR_DATA_o out 49; AR_GRANT_i in 1: read request to arbiter.
- AW_VALID_o out 1; AW_DATA_o out 49; AW_GRANT_i in 1: write request to arbiter.
- W_VALID_o out 1; W_DATA_o out 37; W_GRANT_i in 1: write data to arbiter.
- R_VALID_i in 1; R_DATA_i in 43; R_POP_o out 1: read return from crossbar.
- B_VALID_i in 1; B_DATA_i in 10; B_POP_o out 1: write response return.
- WLAST_ERR_o out 1: sticky WLAST mismatch flag.

## Operation
- Packing: AR/AW word = {MASTER_ID, ID, ADDR, LEN, SIZE, BURST} = 49 b. W word = {DATA, STRB, LAST} = 37 b. R word = {ID8, DATA, RESP, LAST} = 43 b. B word = {ID8, RESP} = 10 b.
- AR path: one-entry buffer. ARREADY_o = ~ar_full & (rd_cnt < MAX_OUTSTANDING). Accepting loads the buffer. AR_GRANT_i with AR_VALID_o empties it and increments rd_cnt.
- R path, combinational: RVALID_o = R_VALID_i. RID_o = R_DATA_i[38:35]. R_POP_o = R_VALID_i & RREADY_i. A pop with RLAST decrements rd_cnt.
- Write FSM, states W_IDLE and W_DATA.
  - W_IDLE: AWREADY_o = ~aw_full & (wr_cnt < MAX_OUTSTANDING), WREADY_o = 0. AW accept latches AWLEN into len_q, clears beat_cnt, then goes to W_DATA.
  - W_DATA: AWREADY_o = 0, WREADY_o = ~w_full. Each accepted beat is loaded into the one-entry W buffer. The LAST bit is set to (beat_cnt == len_q), not taken from WLAST_i. The last accepted beat returns the FSM to W_IDLE.
- AW buffer behaves like AR. AW grant increments wr_cnt.
- B path: BVALID_o = B_VALID_i, BID_o = B_DATA_i[5:2], B_POP_o = B_VALID_i & BREADY_i. A pop decrements wr_cnt.
- Counters: a simultaneous increment and decrement leaves the count unchanged. The counters never exceed MAX_OUTSTANDING and never underflow. A pop at zero holds the count at 0.

## Timing
- Reset values:
  - All *_VALID_o = 0; ARREADY_o = AWREADY_o = 1; WREADY_o = 0.
  - R_POP_o, B_POP_o, RVALID_o, BVALID_o follow inputs.
  - FSM in W_IDLE; counters, beat_cnt, len_q and WLAST_ERR_o = 0.
- Request latency: master accept at edge N, then *_VALID_o high from cycle N+1.
- The buffer holds its data stable until grant. A grant in the same cycle as a new accept is not possible, because READY = ~full.
- Buffers do not allow a fill and a drain in the same cycle, so throughput is 1 beat per 2 cycles.
- The first W beat can be accepted in the cycle after AW accept.
- Reset asserted mid-burst immediately empties the buffers and returns the FSM to W_IDLE. Partially sent bursts are abandoned.

## Configuration
- AXI_M_PORT_LAST_CHK_EN defined: on each accepted W beat, WLAST_i != (beat_cnt == len_q) sets WLAST_ERR_o until reset. The forwarded LAST is still the computed value.
- Undefined: WLAST_ERR_o is tied to 0, and WLAST_i is ignored.

## Test plan
- Single read: MASTER_ID=2, ARID_i=5, ARADDR_i=0x1000_0040, LEN=3 -> AR_DATA_o = {8'h25, 32'h1000_0040, 4'd3, SIZE, BURST}, valid 1 cycle after accept, cleared on grant.
- Outstanding limit: MAX_OUTSTANDING=2, three reads with no R returned -> ARREADY_o low after 2 grants. R pop with RLAST=1 -> ARREADY_o high the next cycle.
- Write burst: AWLEN=2, three W beats with WLAST_i=1 only on beat 3 -> W_DATA_o LAST = 0, 0, 1. WREADY_o = 0 before AW accept and after beat 3.
- WLAST mismatch, macro defined: AWLEN=1 and WLAST_i=1 on beat 1 -> WLAST_ERR_o = 1, forwarded LAST = 0 then 1. With the macro undefined, WLAST_ERR_o stays 0.
- Response return: R_DATA_i ID=8'h27, RREADY_i=0 -> RVALID_o = 1, RID_o = 7, R_POP_o = 0. Raising RREADY_i -> R_POP_o = 1. A B pop and an AW grant in the same cycle leave wr_cnt unchanged.
- Reset mid-burst: assert AXI_RST_i after beat 1 of a LEN=3 burst -> all valids 0, AWREADY_o = 1, WREADY_o = 0.
